// File: rtl/stream_decipher_pkg.sv
// stream_decipher_pkg: shared FSM states, seed width and keystream feedback taps.
// Bytes carry a 9th parity bit when STREAM_DECIPHER_PARITY_EN is defined.
package stream_decipher_pkg;

    typedef enum logic [1:0] {IDLE, WARMUP, RUN, HOLD} state_t;

    localparam int SEED_W = 24;

    // Linear taps s0,s5,s6,s9,s17,s22 and the four AND-term tap groups.
    localparam logic [SEED_W-1:0] LIN_TAPS  = 24'h420261;
    localparam logic [SEED_W-1:0] AND_TAP0  = 24'h002010;
    localparam logic [SEED_W-1:0] AND_TAP1  = 24'h010100;
    localparam logic [SEED_W-1:0] AND_TAP2  = 24'h004820;
    localparam logic [SEED_W-1:0] AND_TAP3  = 24'h000524;

    function automatic logic ks_feedback(input logic [SEED_W-1:0] s);
        return ^(s & LIN_TAPS) ^ (&(s | ~AND_TAP0)) ^ (&(s | ~AND_TAP1))
             ^ (&(s | ~AND_TAP2)) ^ (&(s | ~AND_TAP3));
    endfunction

endpackage

// File: rtl/stream_decipher_if.sv
// stream_decipher_if: ciphertext bit stream in, plaintext byte stream out.
// parity_err exists only when STREAM_DECIPHER_PARITY_EN is defined.
interface stream_decipher_if;
    logic       ct_valid;
    logic       ct_bit;
    logic       ct_ready;
    logic       pt_valid;
    logic [7:0] pt_byte;
    logic       pt_ready;
`ifdef STREAM_DECIPHER_PARITY_EN
    logic       parity_err;
`endif

    modport slave (
        input  ct_valid, ct_bit, pt_ready,
        output ct_ready, pt_valid, pt_byte
`ifdef STREAM_DECIPHER_PARITY_EN
        , output parity_err
`endif
    );

    modport master (
        output ct_valid, ct_bit, pt_ready,
        input  ct_ready, pt_valid, pt_byte
`ifdef STREAM_DECIPHER_PARITY_EN
        , input parity_err
`endif
    );
endinterface

// File: rtl/stream_decipher_ks_gen.sv
// ks_gen: 24-bit nonlinear feedback keystream register; ks_bit is s[0] before each shift.
module ks_gen
    import stream_decipher_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [SEED_W-1:0] seed,
    output logic              ks_bit
);
    logic [SEED_W-1:0] s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) s <= '0;
        else if (load) s <= seed;
        else if (shift) s <= {ks_feedback(s), s[SEED_W-1:1]};
    end

    assign ks_bit = s[0];
endmodule

// File: rtl/stream_decipher.sv
// stream_decipher: XORs a serial ciphertext stream with the ks_gen keystream into plaintext bytes.
// STREAM_DECIPHER_PARITY_EN adds a decrypted 9th bit per byte and the parity_err output.
module stream_decipher
    import stream_decipher_pkg::*;
#(
    parameter int WARMUP_CYCLES = 48,
    parameter int FRAME_BYTES   = 16
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SEED_W-1:0] seed,
    output logic              busy,
    output logic              done,
    stream_decipher_if.slave  ds
);
`ifdef STREAM_DECIPHER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif
    localparam int BW = $clog2(NB);

    state_t        state, state_nxt;
    logic [7:0]    warm_cnt, byte_cnt, pt_q;
    logic [BW-1:0] bit_cnt;
    logic [NB-1:0] asm_q, asm_nxt;
    logic          ks_bit, ks_load, ks_shift, accept, handoff, last_bit, last_byte;

    ks_gen u_ks (
        .clk    (clk),
        .rst    (rst),
        .load   (ks_load),
        .shift  (ks_shift),
        .seed   (seed),
        .ks_bit (ks_bit)
    );

    assign last_bit  = bit_cnt == BW'(NB - 1);
    assign last_byte = byte_cnt == 8'(FRAME_BYTES - 1);
    assign accept    = state == RUN && ds.ct_valid;
    assign handoff   = state == HOLD && ds.pt_ready;
    // Bit 0 of each byte starts from a clean word so stale bits never leak in.
    assign asm_nxt   = (bit_cnt == '0 ? '0 : asm_q) | (NB'(ds.ct_bit ^ ks_bit) << bit_cnt);

    assign busy        = state != IDLE;
    assign ds.ct_ready = state == RUN;
    assign ds.pt_valid = state == HOLD;
    assign ds.pt_byte  = pt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ks_load   = 1'b0;
        ks_shift  = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) begin
                ks_load   = 1'b1;
                state_nxt = WARMUP_CYCLES == 0 ? RUN : WARMUP;
            end
            WARMUP: begin
                ks_shift = 1'b1;
                if (warm_cnt == 8'(WARMUP_CYCLES - 1)) state_nxt = RUN;
            end
            RUN: if (ds.ct_valid) begin
                ks_shift = 1'b1;
                if (last_bit) state_nxt = HOLD;
            end
            HOLD: if (ds.pt_ready) begin
                done      = last_byte;
                state_nxt = last_byte ? IDLE : RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            warm_cnt      <= '0;
            byte_cnt      <= '0;
            bit_cnt       <= '0;
            asm_q         <= '0;
            pt_q          <= '0;
`ifdef STREAM_DECIPHER_PARITY_EN
            ds.parity_err <= 1'b0;
`endif
        end else begin
            if (ks_load) begin
                warm_cnt <= '0;
                bit_cnt  <= '0;
                byte_cnt <= '0;
            end
            if (state == WARMUP) warm_cnt <= warm_cnt + 1'b1;
            if (accept) begin
                asm_q   <= asm_nxt;
                bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
                if (last_bit) pt_q <= asm_nxt[7:0];
`ifdef STREAM_DECIPHER_PARITY_EN
                if (last_bit) ds.parity_err <= asm_nxt[NB-1] ^ (^asm_nxt[7:0]);
`endif
            end
            if (handoff) byte_cnt <= last_byte ? '0 : byte_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_stream_decipher.sv
// tb_stream_decipher: directed bench for stream_decipher with a keystream reference model.
// Honours STREAM_DECIPHER_PARITY_EN (9-bit bytes, parity_err checks).
module tb_stream_decipher;
`ifdef STREAM_DECIPHER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif
    localparam int WA = 0, FA = 2, WB = 48, FB = 3;

    logic        clk = 0, rst = 0, start = 0, sel = 0;
    logic        ct_valid = 0, ct_bit = 0, pt_ready = 1;
    logic [23:0] seed = '0;
    logic        busy_a, done_a, busy_b, done_b;
    logic        busy, done, ct_ready, pt_valid;
    logic [7:0]  pt_byte;

    always #5 clk = ~clk;

    stream_decipher_if ifa ();
    stream_decipher_if ifb ();
    assign ifa.ct_valid = ct_valid;
    assign ifa.ct_bit   = ct_bit;
    assign ifa.pt_ready = pt_ready;
    assign ifb.ct_valid = ct_valid;
    assign ifb.ct_bit   = ct_bit;
    assign ifb.pt_ready = pt_ready;

    stream_decipher #(.WARMUP_CYCLES(WA), .FRAME_BYTES(FA)) dut_a (
        .clk(clk), .rst(rst), .start(start & ~sel), .seed(seed), .busy(busy_a), .done(done_a), .ds(ifa));
    stream_decipher #(.WARMUP_CYCLES(WB), .FRAME_BYTES(FB)) dut_b (
        .clk(clk), .rst(rst), .start(start & sel), .seed(seed), .busy(busy_b), .done(done_b), .ds(ifb));

    assign busy     = sel ? busy_b : busy_a;
    assign done     = sel ? done_b : done_a;
    assign ct_ready = sel ? ifb.ct_ready : ifa.ct_ready;
    assign pt_valid = sel ? ifb.pt_valid : ifa.pt_valid;
    assign pt_byte  = sel ? ifb.pt_byte : ifa.pt_byte;
`ifdef STREAM_DECIPHER_PARITY_EN
    logic perr;
    assign perr = sel ? ifb.parity_err : ifa.parity_err;
    logic got_p[$];
`endif

    int n_cmp = 0, n_err = 0;
    int n_start = 0, n_abort = 0, n_end = 0, done_cnt = 0, stall_seen = 0, stall_left = 0;
    int exp_wr = 0, rd = 0, flush_base = 0;
    logic [7:0] exp_b [256];
    logic       exp_p [256];
    logic       exp_l [256];
    logic [7:0] got [$];
    logic [23:0] cur_seed;
    int cur_w, cur_f, cur_k;
    logic exp_busy;
    assign exp_busy = n_start != n_end + n_abort;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Keystream bit n after seed load, straight from the feedback equation.
    function automatic logic ks_at(input logic [23:0] sd, input int n);
        logic [23:0] s;
        logic fb;
        s = sd;
        for (int i = 0; i < n; i++) begin
            fb = s[0]^s[5]^s[6]^s[9]^s[17]^s[22]^(s[4]&s[13])^(s[8]&s[16])
               ^(s[5]&s[11]&s[14])^(s[2]&s[5]&s[8]&s[10]);
            s = {fb, s[23:1]};
        end
        return s[0];
    endfunction

    task automatic do_start(input logic [23:0] sd);
        cur_seed = sd;
        cur_w = sel ? WB : WA;
        cur_f = sel ? FB : FA;
        cur_k = 0;
        start = 1; seed = sd;
        @(posedge clk); #1;
        start = 0;
        n_start++;
    endtask

    task automatic send_bit(input logic b);
        logic r;
        int n;
        ct_valid = 1; ct_bit = b; r = 0; n = 0;
        while (!r && n < 400) begin
            @(negedge clk); r = ct_ready;
            @(posedge clk); #1;
            n++;
        end
        if (!r) begin
            n_cmp++; n_err++;
            $display("FAIL ct_accept_timeout: ct_ready got 0 expected 1");
        end
    endtask

    task automatic send_byte(input logic [7:0] ct, input logic p9);
        logic [7:0] pb;
        int base;
        base = cur_w + cur_k * NB;
        for (int i = 0; i < 8; i++) pb[i] = ct[i] ^ ks_at(cur_seed, base + i);
        exp_b[exp_wr] = pb;
        exp_l[exp_wr] = cur_k == cur_f - 1;
        exp_p[exp_wr] = (p9 ^ ks_at(cur_seed, base + 8)) != ^pb;
        exp_wr++;
        cur_k = cur_k == cur_f - 1 ? 0 : cur_k + 1;
        for (int i = 0; i < 8; i++) send_bit(ct[i]);
`ifdef STREAM_DECIPHER_PARITY_EN
        send_bit(p9);
`endif
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        ct_valid = 0;
        while (exp_busy && n < 2000) begin @(posedge clk); #1; n++; end
        chk("frame_completion", exp_busy, 0);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    // Consumer: optional back-pressure of stall_left cycles on the next byte.
    initial forever begin
        @(posedge clk); #1;
        if (pt_valid && stall_left > 0) begin
            pt_ready = 0;
            stall_left--;
        end else pt_ready = 1;
    end

    // Compare process: checks outputs against the model on every cycle.
    initial forever begin
        logic hv;
        @(negedge clk);
        if (rd < flush_base) rd = flush_base;
        chk("busy", busy, exp_busy);
        if (!exp_busy || pt_valid) chk("ct_ready_low", ct_ready, 0);
        hv = pt_valid && rd < exp_wr;
        if (pt_valid && !hv) begin
            n_cmp++; n_err++;
            $display("FAIL pt_valid_unexpected: got 1 expected 0");
        end
        if (hv) begin
            chk("pt_byte", pt_byte, exp_b[rd]);
`ifdef STREAM_DECIPHER_PARITY_EN
            chk("parity_err", perr, exp_p[rd]);
`endif
        end
        chk("done", done, hv && pt_ready && exp_l[rd]);
        if (pt_valid && !pt_ready) stall_seen++;
        if (done) done_cnt++;
        if (hv && pt_ready) begin
            got.push_back(pt_byte);
`ifdef STREAM_DECIPHER_PARITY_EN
            got_p.push_back(perr);
`endif
            if (exp_l[rd]) n_end++;
            rd++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, s0, d0;
        repeat (2) begin @(posedge clk); #1; end
        chk("rst_busy_a", busy_a, 0);
        chk("rst_busy_b", busy_b, 0);
        chk("rst_ct_ready_a", ifa.ct_ready, 0);
        chk("rst_pt_valid_a", ifa.pt_valid, 0);
        chk("rst_pt_byte_b", ifb.pt_byte, 0);
        chk("rst_done_a", done_a, 0);
        rst = 1;
        @(posedge clk); #1;

        // Zero seed: keystream is all zero, plaintext equals ciphertext.
        g = got.size();
        do_start(24'h000000);
        send_byte(8'hA5, 0);
        send_byte(8'h3C, 0);
        wait_idle();
        chk("t1_byte0", got[g], 8'hA5);
        chk("t1_byte1", got[g+1], 8'h3C);

        // Seed 1: first keystream bit is 1, the next 23 are 0.
        g = got.size();
        do_start(24'h000001);
        send_byte(8'h00, 0);
        send_byte(8'hFF, 1);
        wait_idle();
        chk("t2_byte0", got[g], 8'h01);
        chk("t2_byte1", got[g+1], 8'hFF);

        // Back-pressure for 5 cycles on byte 0, then the same frame unstalled.
        g = got.size();
        s0 = stall_seen;
        stall_left = 5;
        do_start(24'h5A5A5A);
        send_byte(8'h12, 0);
        send_byte(8'h34, 1);
        wait_idle();
        chk("t3_stall_cycles", stall_seen - s0, 5);
        do_start(24'h5A5A5A);
        send_byte(8'h12, 0);
        send_byte(8'h34, 1);
        wait_idle();
        chk("t3_byte0_vs_nostall", got[g], got[g+2]);
        chk("t3_byte1_vs_nostall", got[g+1], got[g+3]);

        // Start raised in the done cycle must be ignored.
        d0 = done_cnt;
        do_start(24'h0F0F0F);
        send_byte(8'h55, 0);
        send_byte(8'hAA, 1);
        start = 1; seed = 24'hFFFFFF;
        @(posedge clk); #1;
        start = 0; ct_valid = 0;
        repeat (4) begin @(posedge clk); #1; end
        chk("t4_busy_after_done", busy, 0);
        chk("t4_done_pulses", done_cnt - d0, 1);

        // Reset after 3 bits abandons the frame; restart reproduces the stream.
        d0 = done_cnt;
        do_start(24'h123456);
        send_bit(1); send_bit(0); send_bit(1);
        rst = 0;
        #1;
        chk("t5_busy", busy, 0);
        chk("t5_ct_ready", ct_ready, 0);
        chk("t5_pt_valid", pt_valid, 0);
        chk("t5_pt_byte", pt_byte, 0);
        chk("t5_done", done, 0);
        n_abort++;
        flush_base = exp_wr;
        ct_valid = 0;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        chk("t5_no_done_on_abort", done_cnt - d0, 0);
        do_start(24'h123456);
        send_byte(8'hC3, 1);
        send_byte(8'h5E, 0);
        wait_idle();

        // Instance with 48 warmup clocks and 3-byte frames.
        sel = 1;
        @(posedge clk); #1;
        d0 = done_cnt;
        do_start(24'hABCDEF);
        send_byte(8'h11, 0);
        send_byte(8'h22, 1);
        send_byte(8'h33, 0);
        wait_idle();
        chk("t6_done_pulses", done_cnt - d0, 1);
        sel = 0;
        @(posedge clk); #1;

`ifdef STREAM_DECIPHER_PARITY_EN
        g = got_p.size();
        do_start(24'h000000);
        send_byte(8'h07, 0);
        send_byte(8'h07, 1);
        wait_idle();
        chk("t7_parity_err_set", got_p[g], 1);
        chk("t7_parity_err_clear", got_p[g+1], 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
